// File: rtl/afifo_rd_logic_pkg.sv
// Shared definitions for the async FIFO read side: pointer width helper,
// output buffer count type, gray/binary conversion and HEADROOM sanity check.
package afifo_rd_logic_pkg;

  // Widest pointer the conversion helpers handle; callers zero-extend into it.
  localparam int MAX_PW = 32;

  // Number of words held in the 2-entry output buffer (0..2).
  typedef logic [1:0] buf_cnt_t;

  // Pointer carries one extra bit above the address to tell full from empty.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended gray input decodes to the zero-extended binary value.
  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
    logic [MAX_PW-1:0] b;
    b = '0;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // alEmpty threshold must be reachable by the depth counter.
  function automatic bit headroom_ok(input int headroom, input int aw);
    return (headroom >= 1) && (headroom <= (1 << aw));
  endfunction

endpackage

// File: rtl/afifo_rd_logic_if.sv
// Output stream of the async FIFO read side: valid/ready handshake with data.
interface afifo_rd_logic_if #(
  parameter int DW = 64
) ();
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // FIFO side drives the word, consumer drives ready.
  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/afifo_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset, any width.
// Only safe for gray-coded (single-bit-change) buses.
module afifo_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two stages to let the first flop resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/afifo_rd_logic.sv
// Async FIFO read-clock-domain control.
// Synchronises the write gray pointer, tracks empty, issues memory reads and
// feeds a 2-entry first-word-fall-through output buffer at one word per clock.
// Optional feature: define AFIFO_ALEMPTY_EN to build the depth register and
// alEmpty flag; otherwise alEmpty is tied low.
module afifo_rd_logic
  import afifo_rd_logic_pkg::*;
#(
  parameter int DW       = 64,
  parameter int AW       = 15,
  parameter int PW       = ptr_width(AW),
  parameter int HEADROOM = 4
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic [PW-1:0]     wr_gray_ptr,
  input  logic [DW-1:0]     rd_data,
  output logic              ren,
  output logic [AW-1:0]     rd_addr,
  output logic [PW-1:0]     rd_gray_ptr,
  output logic              empty,
  output logic              alEmpty,
  afifo_rd_logic_if.master  out_if
);

  localparam bit HEADROOM_OK = headroom_ok(HEADROOM, AW);

  logic [PW-1:0] wr_gray_sync;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] rd_gray_reg;
  logic          empty_reg;
  buf_cnt_t      cnt_reg;
  buf_cnt_t      cnt_next;
  logic          rd_pend_reg;
  logic          head_reg;
  logic          tail_idx;
  logic          pop;
  logic [2:0]    credit_use;
  logic [DW-1:0] word_sel [2];

  afifo_sync2 #(.WIDTH(PW)) u_wr_sync (
    .clk   (rclk),
    .rst_n (rst_n),
    .d     (wr_gray_ptr),
    .q     (wr_gray_sync)
  );

  // Decode the synchronised write pointer into binary for comparisons.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) wr_ptr_reg <= '0;
    else        wr_ptr_reg <= PW'(gray2bin(MAX_PW'(wr_gray_sync)));
  end

  // Credit: words buffered plus the one in flight, minus the one leaving now,
  // must leave a free slot before another read is launched.
  assign pop         = out_if.out_valid && out_if.out_ready;
  assign credit_use  = {1'b0, cnt_reg} + {2'b00, rd_pend_reg};
  assign ren         = (rd_ptr_reg != wr_ptr_reg) && (credit_use < (3'd2 + {2'b00, pop}));
  assign rd_ptr_next = rd_ptr_reg + PW'(ren);
  assign cnt_next    = cnt_reg + buf_cnt_t'(rd_pend_reg) - buf_cnt_t'(pop);
  // Tail is taken before this cycle's pop; when full and popping it lands on
  // the slot being vacated, which is read combinationally before the edge.
  assign tail_idx    = head_reg ^ cnt_reg[0];

  // Read pointer, buffer bookkeeping, empty flag and outgoing gray pointer.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg  <= '0;
      rd_gray_reg <= '0;
      empty_reg   <= 1'b1;
      cnt_reg     <= '0;
      rd_pend_reg <= 1'b0;
      head_reg    <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      rd_gray_reg <= PW'(bin2gray(MAX_PW'(rd_ptr_next)));
      empty_reg   <= (rd_ptr_next == wr_ptr_reg);
      cnt_reg     <= cnt_next;
      rd_pend_reg <= ren;
      head_reg    <= head_reg ^ pop;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    logic [DW-1:0] word_reg;

    // Capture returning memory data into this slot when it is the tail.
    always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n)                                      word_reg <= '0;
      else if (rd_pend_reg && (tail_idx == 1'(gi)))    word_reg <= rd_data;
    end

    assign word_sel[gi] = word_reg;
  end

  assign rd_addr          = rd_ptr_reg[AW-1:0];
  assign rd_gray_ptr      = rd_gray_reg;
  assign empty            = empty_reg;
  assign out_if.out_valid = (cnt_reg != 2'd0);
  assign out_if.out_data  = word_sel[head_reg];

`ifdef AFIFO_ALEMPTY_EN
  localparam logic [PW:0] HEADROOM_W = HEADROOM[PW:0];
  logic [PW-1:0] depth_reg;
  logic          al_empty_reg;

  // Occupancy of the memory, then threshold it one cycle later.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      depth_reg    <= '0;
      al_empty_reg <= 1'b1;
    end else begin
      depth_reg    <= wr_ptr_reg - rd_ptr_reg;
      al_empty_reg <= ({1'b0, depth_reg} < HEADROOM_W);
    end
  end

  assign alEmpty = al_empty_reg;
`else
  assign alEmpty = 1'b0;
`endif

  // Credit scheme guarantees a capture into a full buffer always meets a pop.
  a_no_overflow: assert property (@(posedge rclk) disable iff (!rst_n)
    !(rd_pend_reg && (cnt_reg == 2'd2) && !pop));

  a_headroom: assert property (@(posedge rclk) HEADROOM_OK);

endmodule
